// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcode/funct constants, FSM states and control encodings.
// The ADDI states exist only when ADDI_EN is defined.
package mips_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC, S_ALU_WB, S_BRANCH, S_JUMP
`ifdef ADDI_EN
    , S_ADDI_EX, S_ADDI_WB
`endif
  } state_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the R-type funct field to an alu_control code; valid low for unknown funct.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       valid
);
  always_comb begin
    alu_control = ALU_AND;
    valid = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: multi-cycle MIPS control FSM with sticky illegal-instruction flag.
// Define ADDI_EN to add the addi execute/writeback path.
module multi_cycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dest,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal
);
  state_t state;
  logic illegal_q, funct_ok;
  logic [2:0] funct_alu;
  logic fetch_s, decode_s, adr_s, rd_s, mwb_s, wr_s, exec_s, awb_s, br_s, jmp_s, addi_ex_s, addi_wb_s;
  alu_decoder u_alu_decoder (.funct(funct), .alu_control(funct_alu), .valid(funct_ok));
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:   state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE:
          case (opcode)
            OP_LW, OP_SW: state <= S_MEM_ADR;
            OP_RTYPE:     state <= S_EXEC;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
`ifdef ADDI_EN
            OP_ADDI:      state <= S_ADDI_EX;
`endif
            default: begin
              state <= S_FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        S_MEM_ADR: state <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:  state <= mem_ready ? S_MEM_WB : S_MEM_RD;
        S_MEM_WR:  state <= mem_ready ? S_FETCH : S_MEM_WR;
        S_EXEC: begin
          state <= funct_ok ? S_ALU_WB : S_FETCH;
          illegal_q <= illegal_q | ~funct_ok;
        end
`ifdef ADDI_EN
        S_ADDI_EX: state <= S_ADDI_WB;
`endif
        default:   state <= S_FETCH;
      endcase
    end
  // Every state flag is qualified by rst_n so all outputs drop to 0 during reset.
  assign fetch_s  = rst_n && state == S_FETCH;
  assign decode_s = rst_n && state == S_DECODE;
  assign adr_s    = rst_n && state == S_MEM_ADR;
  assign rd_s     = rst_n && state == S_MEM_RD;
  assign mwb_s    = rst_n && state == S_MEM_WB;
  assign wr_s     = rst_n && state == S_MEM_WR;
  assign exec_s   = rst_n && state == S_EXEC;
  assign awb_s    = rst_n && state == S_ALU_WB;
  assign br_s     = rst_n && state == S_BRANCH;
  assign jmp_s    = rst_n && state == S_JUMP;
`ifdef ADDI_EN
  assign addi_ex_s = rst_n && state == S_ADDI_EX;
  assign addi_wb_s = rst_n && state == S_ADDI_WB;
`else
  assign addi_ex_s = 1'b0;
  assign addi_wb_s = 1'b0;
`endif
  assign pc_en       = (fetch_s & mem_ready) | (br_s & zero_flag) | jmp_s;
  assign ir_write    = fetch_s & mem_ready;
  assign i_or_d      = rd_s | wr_s;
  assign mem_write   = wr_s;
  assign reg_write   = mwb_s | awb_s | addi_wb_s;
  assign reg_dest    = awb_s;
  assign mem_to_reg  = mwb_s;
  assign alu_src_a   = adr_s | exec_s | br_s | addi_ex_s;
  assign alu_src_b   = fetch_s ? SRCB_FOUR : decode_s ? SRCB_IMM_SH : (adr_s | addi_ex_s) ? SRCB_IMM : SRCB_REG;
  assign pc_src      = br_s ? PC_ALUOUT : jmp_s ? PC_JUMP : PC_ALU;
  assign alu_control = (fetch_s | decode_s | adr_s | addi_ex_s) ? ALU_ADD : br_s ? ALU_SUB : exec_s ? funct_alu : ALU_AND;
  assign illegal     = rst_n & illegal_q;
endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: directed and randomized instruction streams checked cycle by cycle
// against a per-instruction expected-control sequence built from the instruction rules.
module tb_multi_cycle_control;
`ifdef ADDI_EN
  localparam bit ADDI = 1'b1;
`else
  localparam bit ADDI = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, zero_flag = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dest, mem_to_reg, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [15:0] obs;
  logic model_ill = 1'b0;
  int n_checks = 0, n_pass = 0;
  multi_cycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .pc_en(pc_en), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dest(reg_dest), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_control(alu_control),
    .illegal(illegal)
  );
  always #5 clk = ~clk;
  assign obs = {pc_en, ir_write, i_or_d, mem_write, reg_write, reg_dest, mem_to_reg, alu_src_a,
                alu_src_b, pc_src, alu_control, illegal};
  function automatic logic [15:0] w(input logic pe, irw, iod, mw, rw, rd, m2r, asa,
                                    input logic [1:0] asb, pcs, input logic [2:0] aluc);
    return {pe, irw, iod, mw, rw, rd, m2r, asa, asb, pcs, aluc, model_ill};
  endfunction
  function automatic logic [3:0] alu_ref(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (pe irw iod mw rw rd m2r asa asb pcs aluc ill)", tag, got, exp);
  endtask
  task automatic step(input string tag, input logic [15:0] exp);
    @(negedge clk);
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask
  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      zero_flag = 1'($urandom);
      opcode = 6'($urandom);
      step("reset", 16'h0000);
    end
    rst_n = 1'b1;
    model_ill = 1'b0;
  endtask
  task automatic fetch_decode(input logic [5:0] op, fn, input int fstall);
    opcode = op;
    funct = fn;
    zero_flag = 1'($urandom);
    for (int i = 0; i < fstall; i++) begin
      mem_ready = 1'b0;
      step("fetch_wait", w(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010));
    end
    mem_ready = 1'b1;
    step("fetch", w(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010));
    mem_ready = 1'($urandom);
    step("decode", w(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010));
  endtask
  task automatic run_instr(input logic [5:0] op, fn, input logic z, input int fstall, mstall);
    logic [3:0] ar;
    logic st;
    fetch_decode(op, fn, fstall);
    if (op == 6'b100011 || op == 6'b101011) begin
      st = (op == 6'b101011);
      mem_ready = 1'($urandom);
      step("mem_adr", w(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010));
      for (int i = 0; i <= mstall; i++) begin
        mem_ready = (i == mstall);
        step(st ? "mem_wr" : "mem_rd", w(0,0,1,st,0,0,0,0,2'b00,2'b00,3'b000));
      end
      mem_ready = 1'($urandom);
      if (!st) step("mem_wb", w(0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000));
    end else if (op == 6'b000000) begin
      ar = alu_ref(fn);
      mem_ready = 1'($urandom);
      step("exec", w(0,0,0,0,0,0,0,1,2'b00,2'b00,ar[2:0]));
      if (ar[3]) step("alu_wb", w(0,0,0,0,1,1,0,0,2'b00,2'b00,3'b000));
      else model_ill = 1'b1;
    end else if (op == 6'b000100) begin
      zero_flag = z;
      step("branch", w(z,0,0,0,0,0,0,1,2'b00,2'b01,3'b110));
    end else if (op == 6'b000010) begin
      step("jump", w(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b000));
    end else if (op == 6'b001000 && ADDI) begin
      step("addi_ex", w(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010));
      step("addi_wb", w(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000));
    end else model_ill = 1'b1;
  endtask
  logic [5:0] r_op, r_fn;
  int sel;
  initial begin
    #1;
    reset_cycles(3);
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 2);
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
    run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000010, 6'b000000, 1'b0, 1, 0);
    run_instr(6'b101011, 6'b000000, 1'b0, 2, 1);
    fetch_decode(6'b101011, 6'b000000, 0);
    mem_ready = 1'b0;
    step("mem_adr", w(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010));
    step("sw_stall", w(0,0,1,1,0,0,0,0,2'b00,2'b00,3'b000));
    reset_cycles(1);
    mem_ready = 1'b0;
    step("fetch_after_rst", w(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010));
    mem_ready = 1'b1;
    step("fetch_after_rst_go", w(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010));
    reset_cycles(1);
    run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b000111, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);
    reset_cycles(2);
    for (int k = 0; k < 80; k++) begin
      sel = $urandom_range(0, 9);
      r_fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) :
             (sel[0] ? 6'b100101 : ($urandom_range(0, 1) == 1 ? 6'b101010 : 6'b100100));
      case (sel)
        0, 1: r_op = 6'b100011;
        2:    r_op = 6'b101011;
        3, 4: r_op = 6'b000000;
        5:    r_op = 6'b000100;
        6:    r_op = 6'b000010;
        7:    r_op = 6'b001000;
        default: r_op = 6'($urandom);
      endcase
      if (k == 40) reset_cycles(1);
      run_instr(r_op, r_fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
